// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding bus read, holds one instruction + word PC until consumed.
// Optional one-entry sequential prefetch enabled by defining INSTRUCTION_FETCH_PREFETCH_EN.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        system_bus_ready,
    output logic [29:0] system_bus_addr,
    output logic        system_bus_read_req,
    input  logic [31:0] system_bus_read_data,
    input  logic        system_bus_read_data_valid,
    output logic        instruction_valid,
    output logic [29:0] pc_value,
    output logic [31:0] instruction,
    input  logic        consume,
    input  logic [31:0] next_pc
);

    typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [29:0] fetch_pc_q, fetch_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic [29:0] pc_value_q, pc_value_d;
    logic [31:0] instruction_q, instruction_d;

    logic [29:0] next_word;
    logic        unused_next_pc_bits;

    assign next_word           = next_pc[31:2];
    assign unused_next_pc_bits = ^next_pc[1:0];

`ifdef INSTRUCTION_FETCH_PREFETCH_EN
    logic        pf_pending_q, pf_pending_d;
    logic        pf_full_q, pf_full_d;
    logic [29:0] pf_addr_q, pf_addr_d;
    logic [31:0] pf_data_q, pf_data_d;
    logic        pf_req;
    logic        pf_have;
    logic        pf_busy;
    logic        pf_hit;
    logic [29:0] pf_target;
    logic [31:0] pf_word;

    // A prefetch accepted or answered in the same cycle as consume counts as outstanding/buffered.
    assign pf_target = pf_req ? (pc_value_q + 30'd1) : pf_addr_q;
    assign pf_have   = pf_full_q || (pf_pending_q && system_bus_read_data_valid);
    assign pf_busy   = (pf_pending_q && !system_bus_read_data_valid) || (pf_req && system_bus_ready);
    assign pf_hit    = (next_word == pf_target);
    assign pf_word   = pf_full_q ? pf_data_q : system_bus_read_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ISSUE;
            fetch_pc_q    <= RESET_PC[31:2];
            instr_valid_q <= 1'b0;
            pc_value_q    <= '0;
            instruction_q <= '0;
`ifdef INSTRUCTION_FETCH_PREFETCH_EN
            pf_pending_q  <= 1'b0;
            pf_full_q     <= 1'b0;
            pf_addr_q     <= '0;
            pf_data_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            instr_valid_q <= instr_valid_d;
            pc_value_q    <= pc_value_d;
            instruction_q <= instruction_d;
`ifdef INSTRUCTION_FETCH_PREFETCH_EN
            pf_pending_q  <= pf_pending_d;
            pf_full_q     <= pf_full_d;
            pf_addr_q     <= pf_addr_d;
            pf_data_q     <= pf_data_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        instr_valid_d = instr_valid_q;
        pc_value_d    = pc_value_q;
        instruction_d = instruction_q;
`ifdef INSTRUCTION_FETCH_PREFETCH_EN
        pf_pending_d  = pf_pending_q;
        pf_full_d     = pf_full_q;
        pf_addr_d     = pf_addr_q;
        pf_data_d     = pf_data_q;
`endif
        case (state_q)
            ISSUE: begin
                if (system_bus_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (system_bus_read_data_valid) begin
                    instruction_d = system_bus_read_data;
                    pc_value_d    = fetch_pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
`ifdef INSTRUCTION_FETCH_PREFETCH_EN
                if (pf_pending_q && system_bus_read_data_valid) begin
                    pf_pending_d = 1'b0;
                    pf_full_d    = 1'b1;
                    pf_data_d    = system_bus_read_data;
                end else if (pf_req && system_bus_ready) begin
                    pf_pending_d = 1'b1;
                    pf_addr_d    = pc_value_q + 30'd1;
                end
                if (consume) begin
                    pf_pending_d  = 1'b0;
                    pf_full_d     = 1'b0;
                    instr_valid_d = 1'b0;
                    fetch_pc_d    = next_word;
                    if (pf_have && pf_hit) begin
                        instr_valid_d = 1'b1;
                        instruction_d = pf_word;
                        pc_value_d    = next_word;
                        state_d       = HOLD;
                    end else if (pf_busy && pf_hit) begin
                        state_d = WAIT;
                    end else if (pf_busy) begin
                        state_d = DISCARD;
                    end else begin
                        state_d = ISSUE;
                    end
                end
`else
                if (consume) begin
                    instr_valid_d = 1'b0;
                    fetch_pc_d    = next_word;
                    state_d       = ISSUE;
                end
`endif
            end
            DISCARD: begin
                if (system_bus_read_data_valid) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    // Request is masked while reset is held so the bus never sees a request from a resetting stage.
    always_comb begin
        system_bus_read_req = 1'b0;
        system_bus_addr     = fetch_pc_q;
`ifdef INSTRUCTION_FETCH_PREFETCH_EN
        pf_req              = 1'b0;
`endif
        case (state_q)
            ISSUE: system_bus_read_req = !reset;
            HOLD: begin
`ifdef INSTRUCTION_FETCH_PREFETCH_EN
                if (!pf_pending_q && !pf_full_q && !reset) begin
                    pf_req              = 1'b1;
                    system_bus_read_req = 1'b1;
                    system_bus_addr     = pc_value_q + 30'd1;
                end
`endif
            end
            default: ;
        endcase
    end

    assign instruction_valid = instr_valid_q;
    assign pc_value          = pc_value_q;
    assign instruction       = instruction_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; a small bus responder answers one cycle after accept.
// Prefetch scenarios are compiled only when INSTRUCTION_FETCH_PREFETCH_EN is defined.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        system_bus_ready;
    logic [29:0] system_bus_addr;
    logic        system_bus_read_req;
    logic [31:0] system_bus_read_data;
    logic        system_bus_read_data_valid;
    logic        instruction_valid;
    logic [29:0] pc_value;
    logic [31:0] instruction;
    logic        consume;
    logic [31:0] next_pc;

    int n_compared;
    int n_mismatched;
    int accepts;
    int accept_base;

    instruction_fetch #(.RESET_PC(32'h1000_0000)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .system_bus_ready           (system_bus_ready),
        .system_bus_addr            (system_bus_addr),
        .system_bus_read_req        (system_bus_read_req),
        .system_bus_read_data       (system_bus_read_data),
        .system_bus_read_data_valid (system_bus_read_data_valid),
        .instruction_valid          (instruction_valid),
        .pc_value                   (pc_value),
        .instruction                (instruction),
        .consume                    (consume),
        .next_pc                    (next_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: word 0x0400_0000 holds a NOP, every other word its byte address xor a tag.
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        if (a == 30'h0400_0000) return 32'h0000_0013;
        return {a, 2'b00} ^ 32'h5555_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock: sample the handshake before the edge, then answer an accepted read in the next cycle.
    task automatic applyStimulus();
        logic        acc;
        logic [29:0] a;
        #2;
        acc = system_bus_read_req && system_bus_ready;
        a   = system_bus_addr;
        @(posedge clk);
        #1;
        if (acc) accepts++;
        system_bus_read_data_valid = acc;
        system_bus_read_data       = acc ? mem_word(a) : 32'h0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        accepts      = 0;
        reset = 1'b1;
        system_bus_ready = 1'b1;
        system_bus_read_data = '0;
        system_bus_read_data_valid = 1'b0;
        consume = 1'b0;
        next_pc = '0;

        repeat (3) applyStimulus();
        checkOutput("rst_valid", {31'b0, instruction_valid}, 32'd0);
        checkOutput("rst_req", {31'b0, system_bus_read_req}, 32'd0);
        checkOutput("rst_pc", {2'b0, pc_value}, 32'd0);
        checkOutput("rst_instr", instruction, 32'd0);

        reset = 1'b0;
        #1;
        checkOutput("first_req", {31'b0, system_bus_read_req}, 32'd1);
        checkOutput("first_addr", {2'b0, system_bus_addr}, 32'h0400_0000);
        applyStimulus();
        checkOutput("wait_req", {31'b0, system_bus_read_req}, 32'd0);
        checkOutput("wait_valid", {31'b0, instruction_valid}, 32'd0);
        applyStimulus();
        checkOutput("first_valid", {31'b0, instruction_valid}, 32'd1);
        checkOutput("first_pc", {2'b0, pc_value}, 32'h0400_0000);
        checkOutput("first_instr", instruction, 32'h0000_0013);

        repeat (2) applyStimulus();
        checkOutput("hold_valid", {31'b0, instruction_valid}, 32'd1);
        checkOutput("hold_instr", instruction, 32'h0000_0013);
`ifndef INSTRUCTION_FETCH_PREFETCH_EN
        checkOutput("hold_req", {31'b0, system_bus_read_req}, 32'd0);
`endif

        consume = 1'b1;
        next_pc = 32'h1000_0040;
        system_bus_ready = 1'b0;
        applyStimulus();
        consume = 1'b0;
        checkOutput("cons_valid", {31'b0, instruction_valid}, 32'd0);
        checkOutput("cons_req", {31'b0, system_bus_read_req}, 32'd1);
        checkOutput("cons_addr", {2'b0, system_bus_addr}, 32'h0400_0010);

        accept_base = accepts;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                consume = 1'b1;
                next_pc = 32'hDEAD_BEEC;
            end
            applyStimulus();
            consume = 1'b0;
            checkOutput($sformatf("stall_req%0d", i), {31'b0, system_bus_read_req}, 32'd1);
            checkOutput($sformatf("stall_addr%0d", i), {2'b0, system_bus_addr}, 32'h0400_0010);
        end
        checkOutput("stall_noacc", accepts - accept_base, 32'd0);
        system_bus_ready = 1'b1;
        applyStimulus();
        checkOutput("stall_one_acc", accepts - accept_base, 32'd1);
        applyStimulus();
        checkOutput("stall_valid", {31'b0, instruction_valid}, 32'd1);
        checkOutput("stall_pc", {2'b0, pc_value}, 32'h0400_0010);
        checkOutput("stall_instr", instruction, 32'h4555_0040);
        checkOutput("stall_acc_total", accepts - accept_base, 32'd1);

`ifdef INSTRUCTION_FETCH_PREFETCH_EN
        repeat (2) applyStimulus();
`endif
        consume = 1'b1;
        next_pc = 32'h1000_0080;
        applyStimulus();
        consume = 1'b0;
        checkOutput("rw_addr", {2'b0, system_bus_addr}, 32'h0400_0020);
        applyStimulus();
        reset = 1'b1;
        system_bus_read_data_valid = 1'b0;
        applyStimulus();
        checkOutput("rw_req", {31'b0, system_bus_read_req}, 32'd0);
        checkOutput("rw_valid", {31'b0, instruction_valid}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rw_restart_addr", {2'b0, system_bus_addr}, 32'h0400_0000);
        applyStimulus();
        applyStimulus();
        checkOutput("rw_restart_pc", {2'b0, pc_value}, 32'h0400_0000);
        checkOutput("rw_restart_instr", instruction, 32'h0000_0013);

`ifndef INSTRUCTION_FETCH_PREFETCH_EN
        system_bus_read_data_valid = 1'b1;
        system_bus_read_data = 32'hBAD0_0000;
        applyStimulus();
        checkOutput("stray_instr", instruction, 32'h0000_0013);
        checkOutput("stray_valid", {31'b0, instruction_valid}, 32'd1);
        checkOutput("stray_req", {31'b0, system_bus_read_req}, 32'd0);
`else
        applyStimulus();
        applyStimulus();
        checkOutput("pf_full_pc", {2'b0, pc_value}, 32'h0400_0000);
        checkOutput("pf_full_req", {31'b0, system_bus_read_req}, 32'd0);
        consume = 1'b1;
        next_pc = 32'h1000_0004;
        applyStimulus();
        consume = 1'b0;
        checkOutput("pf_hit_valid", {31'b0, instruction_valid}, 32'd1);
        checkOutput("pf_hit_pc", {2'b0, pc_value}, 32'h0400_0001);
        checkOutput("pf_hit_instr", instruction, 32'h4555_0004);

        applyStimulus();
        applyStimulus();
        consume = 1'b1;
        next_pc = 32'h1000_0100;
        applyStimulus();
        consume = 1'b0;
        checkOutput("pf_miss_valid", {31'b0, instruction_valid}, 32'd0);
        checkOutput("pf_miss_addr", {2'b0, system_bus_addr}, 32'h0400_0040);
        applyStimulus();
        applyStimulus();
        checkOutput("pf_miss_instr", instruction, 32'h4555_0100);

        applyStimulus();
        system_bus_read_data_valid = 1'b0;
        consume = 1'b1;
        next_pc = 32'h1000_0200;
        applyStimulus();
        consume = 1'b0;
        checkOutput("pf_disc_req", {31'b0, system_bus_read_req}, 32'd0);
        system_bus_read_data_valid = 1'b1;
        system_bus_read_data = mem_word(30'h0400_0041);
        applyStimulus();
        checkOutput("pf_disc_addr", {2'b0, system_bus_addr}, 32'h0400_0080);
        applyStimulus();
        applyStimulus();
        checkOutput("pf_disc_instr", instruction, 32'h4555_0200);

        applyStimulus();
        system_bus_read_data_valid = 1'b0;
        consume = 1'b1;
        next_pc = 32'h1000_0204;
        applyStimulus();
        consume = 1'b0;
        checkOutput("pf_wait_valid", {31'b0, instruction_valid}, 32'd0);
        system_bus_read_data_valid = 1'b1;
        system_bus_read_data = mem_word(30'h0400_0081);
        applyStimulus();
        checkOutput("pf_wait_pc", {2'b0, pc_value}, 32'h0400_0081);
        checkOutput("pf_wait_instr", instruction, 32'h4555_0204);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
